// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - handshake/operand/result bundle for mult_div_unit
// Ports: MultCtrl/DivCtrl start strobes, Unsigned mode, A/B operands (master -> slave);
//        HI/LO results, Busy, MultStop/DivStop/DivZero completion pulses (slave -> master).
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             MultCtrl;
  logic             DivCtrl;
  logic             Unsigned;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;
  logic             MultStop;
  logic             DivStop;
  logic             DivZero;

  modport master (
    output MultCtrl, DivCtrl, Unsigned, A, B,
    input  HI, LO, Busy, MultStop, DivStop, DivZero
  );

  modport slave (
    input  MultCtrl, DivCtrl, Unsigned, A, B,
    output HI, LO, Busy, MultStop, DivStop, DivZero
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed/unsigned shift-add multiply and restoring divide
// Ports: clk (rising edge), reset (async, active low), bus (mult_div_unit_if.slave):
//        start strobes and operands in, HI/LO results, Busy and Stop/DivZero pulses out.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DZERO} state_t;

  state_t state_q, state_d;

  // acc holds {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide; one spare top bit
  // catches the add carry / trial-subtract borrow.
  logic [2*WIDTH:0] acc_q;
  logic [WIDTH-1:0] opnd_q;     // multiplicand magnitude or divisor magnitude
  logic [CW-1:0]    cnt_q;
  logic             op_div_q;
  logic             neg_q;      // negate product / quotient at the end
  logic             neg_rem_q;  // remainder follows the dividend sign
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             mstop_q, dstop_q, dzero_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [2*WIDTH:0] step_mul, step_div;
  logic [2*WIDTH-1:0] prod, res_mul;
  logic [WIDTH-1:0] quo, rem;

  assign a_neg = !bus.Unsigned && bus.A[WIDTH-1];
  assign b_neg = !bus.Unsigned && bus.B[WIDTH-1];
  assign a_mag = a_neg ? -bus.A : bus.A;
  assign b_mag = b_neg ? -bus.B : bus.B;

  // One shift-add multiply step: add multiplicand when the low multiplier bit is set.
  assign sum      = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign step_mul = {sum, acc_q[WIDTH-1:0]} >> 1;

  // One restoring divide step: shift in the next dividend bit and trial-subtract.
  assign shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, opnd_q};
  assign step_div = diff[WIDTH] ? {shifted, acc_q[WIDTH-2:0], 1'b0}
                                : {diff,    acc_q[WIDTH-2:0], 1'b1};

  assign prod    = acc_q[2*WIDTH-1:0];
  assign res_mul = neg_q ? -prod : prod;
  assign quo     = acc_q[WIDTH-1:0];
  assign rem     = acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.MultCtrl)     state_d = RUN;
        else if (bus.DivCtrl) state_d = (bus.B == '0) ? DZERO : RUN;
      end
      RUN:     if (cnt_q == CW'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      DZERO:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      op_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      mstop_q   <= 1'b0;
      dstop_q   <= 1'b0;
      dzero_q   <= 1'b0;
    end else begin
      mstop_q <= 1'b0;
      dstop_q <= 1'b0;
      dzero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.MultCtrl) begin
            acc_q    <= {{(WIDTH+1){1'b0}}, b_mag};
            opnd_q   <= a_mag;
            neg_q    <= a_neg ^ b_neg;
            op_div_q <= 1'b0;
            cnt_q    <= CW'(WIDTH);
          end else if (bus.DivCtrl && bus.B != '0) begin
            acc_q     <= {{(WIDTH+1){1'b0}}, a_mag};
            opnd_q    <= b_mag;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            op_div_q  <= 1'b1;
            cnt_q     <= CW'(WIDTH);
          end
        end
        RUN: begin
          acc_q <= op_div_q ? step_div : step_mul;
          cnt_q <= cnt_q - 1'b1;
        end
        FINISH: begin
          if (op_div_q) begin
            lo_q    <= neg_q ? -quo : quo;
            hi_q    <= neg_rem_q ? -rem : rem;
            dstop_q <= 1'b1;
          end else begin
            {hi_q, lo_q} <= res_mul;
            mstop_q      <= 1'b1;
          end
        end
        DZERO: begin
          dstop_q <= 1'b1;
          dzero_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign bus.Busy     = (state_q == RUN) || (state_q == FINISH);
  assign bus.MultStop = mstop_q;
  assign bus.DivStop  = dstop_q;
  assign bus.DivZero  = dzero_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit (WIDTH=32 and WIDTH=8)
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) if32();
  mult_div_unit_if #(.WIDTH(8))  if8();

  mult_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
  mult_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          m, d, u;
    logic [31:0] a, b, hi, lo;
    int          lat;
    logic [2:0]  fl;   // {MultStop, DivStop, DivZero}
  } vec_t;

  vec_t tbl[$];
  logic [31:0] mhi, mlo;   // reference copy of HI/LO

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  task automatic model(input bit m, input bit u, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo,
                       output int lat, output logic [2:0] fl);
    logic [63:0] p;
    longint sa, sb, q, r;
    if (m) begin
      if (u) p = {32'b0, a} * {32'b0, b};
      else   p = longint'($signed(a)) * longint'($signed(b));
      hi = p[63:32]; lo = p[31:0]; lat = 33; fl = 3'b100;
    end else if (b == 0) begin
      lat = 1; fl = 3'b011;
    end else begin
      if (u) begin
        lo = a / b; hi = a % b;
      end else begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        lo = q[31:0]; hi = r[31:0];
      end
      lat = 33; fl = 3'b010;
    end
  endtask

  task automatic op32(input bit m, input bit d, input bit u, input logic [31:0] a,
                      input logic [31:0] b, input bit poke, output int lat, output logic [2:0] fl);
    @(negedge clk);
    if32.MultCtrl = m; if32.DivCtrl = d; if32.Unsigned = u; if32.A = a; if32.B = b;
    @(posedge clk);
    @(negedge clk);
    if32.MultCtrl = 0; if32.DivCtrl = 0; if32.Unsigned = ~u; if32.A = $urandom; if32.B = $urandom;
    lat = 0;
    while (!(if32.MultStop || if32.DivStop) && lat < 200) begin
      if (poke && lat == 10) begin
        check("busy_mid_run", 64'(if32.Busy), 64'd1);
        if32.DivCtrl = 1; if32.B = 0;
      end else begin
        if32.DivCtrl = 0;
      end
      @(posedge clk); @(negedge clk); lat++;
    end
    if32.DivCtrl = 0;
    fl = {if32.MultStop, if32.DivStop, if32.DivZero};
    check("busy_at_stop", 64'(if32.Busy), 64'd0);
    @(posedge clk); @(negedge clk);
    check("stop_one_cycle", 64'({if32.MultStop, if32.DivStop, if32.DivZero}), 64'd0);
  endtask

  task automatic run_check(input string tag, input bit m, input bit d, input bit u,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input int elat, input logic [2:0] efl);
    int lat;
    logic [2:0] fl;
    op32(m, d, u, a, b, 1'b0, lat, fl);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_flags"}, 64'(fl), 64'(efl));
    check({tag, "_hi"}, 64'(if32.HI), 64'(ehi));
    check({tag, "_lo"}, 64'(if32.LO), 64'(elo));
  endtask

  task automatic op8(input string tag, input bit u, input bit m, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo,
                     input logic [2:0] efl);
    int lat;
    @(negedge clk);
    if8.MultCtrl = m; if8.DivCtrl = ~m; if8.Unsigned = u; if8.A = a; if8.B = b;
    @(posedge clk);
    @(negedge clk);
    if8.MultCtrl = 0; if8.DivCtrl = 0; if8.A = 8'($urandom); if8.B = 8'($urandom);
    lat = 0;
    while (!(if8.MultStop || if8.DivStop) && lat < 50) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd9);
    check({tag, "_flags"}, 64'({if8.MultStop, if8.DivStop, if8.DivZero}), 64'(efl));
    check({tag, "_hi"}, 64'(if8.HI), 64'(ehi));
    check({tag, "_lo"}, 64'(if8.LO), 64'(elo));
  endtask

  initial begin
    int lat, stops, elat;
    logic [2:0] fl, efl;
    bit m, d, u;
    logic [31:0] a, b;

    // m d u a b hi lo lat flags
    tbl.push_back('{1, 0, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 3'b100});
    tbl.push_back('{0, 1, 0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 3'b010});
    tbl.push_back('{0, 1, 1, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 33, 3'b010});
    tbl.push_back('{1, 0, 1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 33, 3'b100});
    tbl.push_back('{1, 0, 0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 33, 3'b100});
    tbl.push_back('{0, 1, 0, 32'd95,       32'd10,       32'd5,        32'd9,        33, 3'b010});
    tbl.push_back('{0, 1, 0, 32'd1234,     32'd0,        32'd5,        32'd9,        1,  3'b011});
    tbl.push_back('{0, 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 3'b010});
    tbl.push_back('{1, 1, 0, 32'd3,        32'd4,        32'd0,        32'd12,       33, 3'b100});
    tbl.push_back('{1, 1, 0, 32'h1234,     32'd0,        32'd0,        32'd0,        33, 3'b100});
    tbl.push_back('{0, 1, 1, 32'hDEAD,     32'd0,        32'd0,        32'd0,        1,  3'b011});
    tbl.push_back('{0, 1, 0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 3'b010});
    tbl.push_back('{0, 1, 0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        33, 3'b010});
    tbl.push_back('{0, 1, 1, 32'd5,        32'hFFFFFFFF, 32'd5,        32'd0,        33, 3'b010});
    tbl.push_back('{1, 0, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 3'b100});

    if32.MultCtrl = 0; if32.DivCtrl = 0; if32.Unsigned = 0; if32.A = 0; if32.B = 0;
    if8.MultCtrl = 0;  if8.DivCtrl = 0;  if8.Unsigned = 0;  if8.A = 0;  if8.B = 0;
    reset = 0;
    repeat (3) @(negedge clk);
    check("reset_hilo32", {if32.HI, if32.LO}, 64'd0);
    check("reset_flags32", 64'({if32.Busy, if32.MultStop, if32.DivStop, if32.DivZero}), 64'd0);
    check("reset_hilo8", 64'({if8.HI, if8.LO}), 64'd0);
    reset = 1;

    foreach (tbl[i]) begin
      run_check($sformatf("vec%0d", i), tbl[i].m, tbl[i].d, tbl[i].u, tbl[i].a, tbl[i].b,
                tbl[i].hi, tbl[i].lo, tbl[i].lat, tbl[i].fl);
    end

    // DivCtrl with a zero divisor while busy must not disturb the multiply.
    op32(1, 0, 0, 32'd3, 32'd5, 1'b1, lat, fl);
    check("busy_ignore_lat", 64'(lat), 64'd33);
    check("busy_ignore_flags", 64'(fl), 64'(3'b100));
    check("busy_ignore_lo", {if32.HI, if32.LO}, 64'd15);

    // Reset ten cycles into an operation.
    @(negedge clk);
    if32.MultCtrl = 1; if32.Unsigned = 0; if32.A = 32'd7; if32.B = 32'd9;
    @(posedge clk);
    @(negedge clk);
    if32.MultCtrl = 0;
    repeat (9) @(negedge clk);
    reset = 0;
    #1;
    check("midreset_hilo", {if32.HI, if32.LO}, 64'd0);
    check("midreset_flags", 64'({if32.Busy, if32.MultStop, if32.DivStop, if32.DivZero}), 64'd0);
    @(negedge clk);
    reset = 1;
    stops = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if32.MultStop || if32.DivStop || if32.Busy) stops++;
    end
    check("no_stop_after_reset", 64'(stops), 64'd0);
    mhi = 0; mlo = 0;

    // Randomised operations against the reference.
    for (int k = 0; k < 30; k++) begin
      m = 1'($urandom_range(0, 1));
      d = !m || 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      model(m, u, a, b, mhi, mlo, elat, efl);
      run_check($sformatf("rnd%0d", k), m, d, u, a, b, mhi, mlo, elat, efl);
    end

    // Narrow instance.
    op8("w8_mul", 1'b0, 1'b1, 8'h80, 8'h80, 8'h40, 8'h00, 3'b100);
    op8("w8_div", 1'b1, 1'b0, 8'd200, 8'd7, 8'd4, 8'd28, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multicycle multiply/divide engine driven by the main control FSM through MultCtrl/DivCtrl start strobes.
- Returns MultStop/DivStop completion pulses, writes the HI/LO result registers and flags divide-by-zero.
- Generalises the fixed 32-bit signed mult/div to any WIDTH and adds an unsigned mode (multu/divu) selected per operation.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
MultCtrl  input  1  start multiply, sampled only in IDLE.
DivCtrl  input  1  start divide, sampled only in IDLE.
Unsigned  input  1  0 = signed operation, 1 = unsigned; captured at start.
A  input  WIDTH  multiplicand / dividend; captured at start.
B  input  WIDTH  multiplier / divisor; captured at start.
HI  output  WIDTH  mult: upper product half; div: remainder.
LO  output  WIDTH  mult: lower product half; div: quotient.
Busy  output  1  high in RUN and FINISH.
MultStop  output  1  one-cycle pulse: multiply complete.
DivStop  output  1  one-cycle pulse: divide complete, including the div-by-zero abort.
DivZero  output  1  one-cycle pulse coincident with DivStop when the divisor was 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; HI=0, LO=0; Busy, MultStop, DivStop, DivZero all 0; iteration counter = 0.
  - Reset mid-operation aborts the operation; no Stop pulse is ever produced for it.
- States: IDLE, RUN, FINISH, DZERO.
- IDLE:
  - MultCtrl=1 → latch A, B, Unsigned, op=MULT; counter=WIDTH; go to RUN.
  - DivCtrl=1 and B≠0 → same latching with op=DIV; go to RUN.
  - DivCtrl=1 and B==0 → go to DZERO.
  - MultCtrl and DivCtrl both 1 → multiply wins; DivCtrl is ignored.
- RUN:
  - One iteration per cycle; counter decrements each edge.
  - Moves to FINISH on the edge where counter goes 1→0.
  - MultCtrl/DivCtrl are ignored while Busy; no queuing.
- Multiply algorithm:
  - Operate on magnitudes |A|, |B| in signed mode; raw A, B in unsigned mode.
  - Shift-add into a 2*WIDTH accumulator.
  - In FINISH, negate the 2*WIDTH result if signed and the operand signs differ.
  - Result is the exact 2*WIDTH product; no overflow is possible.
- Divide algorithm:
  - Restoring division on magnitudes (signed mode) or raw values (unsigned mode).
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed most-negative / -1: LO = most-negative value (wraps), HI = 0; no flag.
- FINISH (one cycle):
  - Apply the sign fix-up and register HI/LO.
  - Pulse MultStop or DivStop for exactly this one cycle; return to IDLE.
- DZERO (one cycle):
  - DivZero=1 and DivStop=1; HI/LO unchanged; return to IDLE.
- Latency: start sampled at edge E0 → HI/LO updated and Stop high after edge E0+WIDTH+1 (33 cycles for WIDTH=32).
  - Div-by-zero: flags high after E0+1.
- Back-to-back: a new start may be sampled on the edge right after FINISH (IDLE cycle); there is no forwarding from FINISH.
- HI/LO hold their value until the next completed operation; the control FSM reads them via MFHI/MFLO at any time after Stop.
- Operand changes on A/B/Unsigned after the start edge have no effect.

Test Plan:
- WIDTH=32, signed mult A=7, B=0xFFFFFFFD (-3) → after 33 cycles MultStop pulses 1 cycle; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy low the next cycle.
- Signed div A=0xFFFFFFF9 (-7), B=2 → DivStop at cycle 33; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Same operands with Unsigned=1 → LO=0x7FFFFFFC, HI=1.
- Unsigned mult A=0xFFFFFFFF, B=2 → HI=1, LO=0xFFFFFFFE.
  - Same operands signed → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Preload HI=5, LO=9 via a prior op; div with B=0 → next cycle DivZero=DivStop=1 for 1 cycle; HI=5, LO=9 unchanged.
  - Then signed 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MultCtrl and DivCtrl together → multiply performed, only MultStop fires.
  - Assert DivCtrl while Busy → ignored.
  - Pull reset low at cycle 10 of an op → all outputs 0 immediately; no Stop pulse afterwards.
- WIDTH=8 instance: signed mult 0x80*0x80 → HI=0x40, LO=0x00 after 9 cycles.
  - Unsigned div 200/7 → LO=28, HI=4.
